// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// input_conditioner: sync, debounce, auto-repeat and gravity for the
// game buttons, arbitrated into one-cycle move pulses plus a start pulse.
// Ports: clk; rst (async, active-low); btn_right/left/rr/rl/down/start
// raw buttons; gravity_en auto-drop enable; hold pause; right/left/rr/
// rl/down one-hot move pulses; en start pulse.
module input_conditioner #(
  parameter int DB_CYCLES      = 16,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8,
  parameter int GRAVITY_PERIOD = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_right,
  input  logic btn_left,
  input  logic btn_rr,
  input  logic btn_rl,
  input  logic btn_down,
  input  logic btn_start,
  input  logic gravity_en,
  input  logic hold,
  output logic right,
  output logic left,
  output logic rr,
  output logic rl,
  output logic down,
  output logic en
);

  localparam int NB = 6;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int GW = $clog2(GRAVITY_PERIOD + 1);

  // bit order: 0 right, 1 left, 2 rr, 3 rl, 4 down, 5 start
  logic [NB-1:0] raw;
  logic [NB-1:0] s1;
  logic [NB-1:0] s2;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_d;
  logic [NB-1:0] press;
  logic [DW-1:0] db_cnt [NB];

  // repeat slots: 0 right, 1 left, 2 down
  logic [2:0]    rdeb;
  logic [2:0]    rpt_evt;
  logic [RW-1:0] rpt_cnt [3];

  logic [GW-1:0] g_cnt;
  logic          grav_evt;

  logic [4:0] evt;
  logic [4:0] pend;
  logic [4:0] req;
  logic [4:0] sel;

  assign raw = {btn_start, btn_down, btn_rl,
                btn_rr, btn_left, btn_right};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NB; i++)
        db_cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < NB; i++) begin
        if (s2[i] != deb[i]) begin
          if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
            deb[i]    <= s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_d;
  assign rdeb  = {deb[4], deb[1], deb[0]};

  // Counter is 0 in the press cycle and counts cycles held since.
  // After each repeat it reloads so the next hit lands RATE later.
  always_comb begin
    rpt_evt = '0;
    for (int i = 0; i < 3; i++)
      rpt_evt[i] = rdeb[i] &&
                   (rpt_cnt[i] == RW'(REPEAT_DELAY));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++)
        rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!rdeb[i])
          rpt_cnt[i] <= '0;
        else if (rpt_evt[i])
          rpt_cnt[i] <=
            RW'(REPEAT_DELAY - REPEAT_RATE + 1);
        else
          rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
      end
    end
  end

  assign grav_evt = gravity_en && !hold &&
                    (g_cnt == GW'(GRAVITY_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      g_cnt <= '0;
    else if (!gravity_en || sel[4] || grav_evt)
      g_cnt <= '0;
    else if (!hold)
      g_cnt <= g_cnt + GW'(1);
  end

  // sel isolates the lowest set bit: right has top priority.
  always_comb begin
    evt = {press[4] | rpt_evt[2] | grav_evt,
           press[3],
           press[2],
           press[1] | rpt_evt[1],
           press[0] | rpt_evt[0]};
    req = hold ? 5'd0 : (pend | evt);
    sel = req & (~req + 5'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      right <= 1'b0;
      left  <= 1'b0;
      rr    <= 1'b0;
      rl    <= 1'b0;
      down  <= 1'b0;
      en    <= 1'b0;
    end else begin
      pend  <= req & ~sel;
      right <= sel[0];
      left  <= sel[1];
      rr    <= sel[2];
      rl    <= sel[3];
      down  <= sel[4];
      en    <= press[5];
    end
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front end that generates the one-cycle move commands (right, left, rr, rl, down) and the start pulse (en) consumed by the game state machine.
- Synchronizes and debounces raw board buttons, detects presses, and auto-repeats held right/left/down.
- Injects gravity drops and arbitrates so that at most one move pulse is issued per cycle.
- Sits between the top-level button pins and the game FSM.

Parameters:
DB_CYCLES, 16, consecutive cycles a synchronized input must differ from its debounced state before the debounced state flips
REPEAT_DELAY, 32, cycles a right/left/down button must stay held after its press before the first repeat
REPEAT_RATE, 8, cycles between successive repeats while still held
GRAVITY_PERIOD, 64, cycles between automatic down requests when gravity_en=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn_right  in  1  raw button, asynchronous to clk
btn_left  in  1  raw button
btn_rr  in  1  raw button, rotate right
btn_rl  in  1  raw button, rotate left
btn_down  in  1  raw button, soft drop
btn_start  in  1  raw button, start/restart
gravity_en  in  1  enables automatic drop generation
hold  in  1  pause; suppresses all move output
right  out  1  one-cycle move pulse
left  out  1  one-cycle move pulse
rr  out  1  one-cycle move pulse
rl  out  1  one-cycle move pulse
down  out  1  one-cycle move pulse
en  out  1  one-cycle start pulse

Behaviour:
- Reset (rst=0, async): all outputs 0; synchronizers, debounced states, debounce/repeat/gravity counters and pending flags all 0. Counter widths are derived from the parameters via $clog2.
- Synchronizer: 2-FF per button.
- Debounce, per button:
  - Counter increments while the synced value differs from the debounced state; otherwise it clears.
  - When the counter reaches DB_CYCLES-1 and the values still differ, the debounced state flips and the counter clears.
  - A glitch shorter than DB_CYCLES produces no event.
- Press event: rising edge of the debounced state, one cycle.
- Repeat (right, left, down only):
  - Per-button repeat counter starts at the press and runs while the button stays debounced-high.
  - First repeat event at REPEAT_DELAY cycles after the press; subsequent events every REPEAT_RATE cycles.
  - Release clears the counter immediately. rr, rl and start never repeat.
- Gravity:
  - Counter runs while gravity_en=1 and hold=0; at GRAVITY_PERIOD-1 it raises a down request and wraps to 0.
  - gravity_en=0 forces the counter to 0. Any issued down pulse (manual or gravity) clears the counter.
- Pending flags, one per move command:
  - Set by a press/repeat/gravity event; cleared the cycle its pulse is issued.
  - An event for an already-pending command merges into it (no double pulse).
  - Manual down and gravity in the same cycle yield one down pulse.
- Arbitration:
  - Each cycle, the highest-priority pending flag is issued: right > left > rr > rl > down.
  - Outputs are registered, so at most one of right/left/rr/rl/down is high in any cycle.
  - Lower-priority requests wait; a starved request is issued on the first cycle no higher flag is pending.
- hold=1:
  - No move pulses are issued, all pending flags are cleared, and events are discarded.
  - The gravity counter freezes; debounce and repeat counters keep running.
  - en is unaffected by hold.
- en: registered one-cycle pulse on each start press; not arbitrated against moves.
- Latency: with raw input rising before clock edge N and no contention, the output pulse is high in the cycle after edge N+DB_CYCLES+2 (2 sync, DB_CYCLES debounce, 1 output register).
- Reset mid-operation clears all state. A button held through reset deasserts no output and is seen as a fresh press exactly once after debounce.

Test Plan (override DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3, GRAVITY_PERIOD=10):
- Hold btn_rr high for 20 cycles -> exactly one rr pulse, 6 cycles after the first sampled-high edge; no repeats; all other outputs stay 0.
- Pulse btn_left high for 3 cycles, then low -> no left pulse ever; then hold btn_left for 30 cycles -> first pulse at press, then repeat pulses 8, 11, 14, ... cycles after it until release.
- Raise btn_right and btn_down in the same cycle and hold -> right pulse issued first; down pulse one cycle later.
- gravity_en=1, no buttons -> down pulse every 10 cycles. Manual down press mid-period -> gravity phase restarts from that pulse; the coincident case gives a single pulse.
- hold=1 while btn_right is held and gravity_en=1 -> no move pulses. A btn_start press during hold -> en pulses once. Release hold -> the gravity counter resumes from its frozen value.
- Assert rst low for 2 cycles while btn_down is held and its repeat is active -> outputs 0 during reset; after release, one down press 6 cycles later, then repeats per parameters.
